// File: rtl/serial_arith_pkg.sv
// Shared types and sizing helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width for a WIDTH-bit serial operation (WIDTH >= 2).
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake plus operand and result bus of the serial subtractor.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/full_subtractor_gate.sv
// 1-bit full subtractor built from gate primitives, same structure as the adder cell.
module full_subtractor_gate (
    input  wire A,
    input  wire B,
    input  wire Bin,
    output wire Diff,
    output wire Bout
);
    wire axb;
    wire na;
    wire nab;
    wire t0;
    wire t1;

    xor g_x0 (axb, A, B);
    xor g_x1 (Diff, axb, Bin);
    not g_n0 (na, A);
    and g_a0 (t0, na, B);
    // Borrow propagates through equal bits.
    not g_n1 (nab, axb);
    and g_a1 (t1, nab, Bin);
    or  g_o0 (Bout, t0, t1);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per clock.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             d_bit;
    logic             b_next;

    full_subtractor_gate u_fs (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Bin  (br_q),
        .Diff (d_bit),
        .Bout (b_next)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        diff_d  = diff_q;
        br_d    = br_q;
        bout_d  = bout_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    br_d    = bus.bin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {d_bit, res_q[WIDTH-1:1]};
                br_d  = b_next;
                cnt_d = cnt_q + 1'b1;
                // Last bit: publish the result in the same edge it is formed.
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    diff_d  = {d_bit, res_q[WIDTH-1:1]};
                    bout_d  = b_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH 8 and an exhaustive sweep at WIDTH 4.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   dones;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        bus8.a     = av;
        bus8.b     = bv;
        bus8.bin   = bi;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
    endtask

    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic bi, input logic [7:0] ed, input logic eb);
        start8(av, bv, bi);
        for (int k = 1; k <= 8; k++) begin
            chk({tag, "_busy"}, 32'(bus8.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus8.done), 32'd0);
            step();
        end
        chk({tag, "_done"}, 32'(bus8.done), 32'd1);
        chk({tag, "_idle"}, 32'(bus8.busy), 32'd0);
        chk({tag, "_diff"}, 32'(bus8.diff), 32'(ed));
        chk({tag, "_bout"}, 32'(bus8.bout), 32'(eb));
    endtask

    initial begin
        logic [4:0] ref4;

        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        bus8.start = 1'b0;
        bus8.a     = '0;
        bus8.b     = '0;
        bus8.bin   = 1'b0;
        bus4.start = 1'b0;
        bus4.a     = '0;
        bus4.b     = '0;
        bus4.bin   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_done", 32'(bus8.done), 32'd0);
        chk("rst_diff", 32'(bus8.diff), 32'd0);
        chk("rst_bout", 32'(bus8.bout), 32'd0);
        chk("rst4_diff", 32'(bus4.diff), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic operations
        op8("t1", 8'd100, 8'd37, 1'b0, 8'd63, 1'b0);
        step();
        chk("t1_after", 32'(bus8.done), 32'd0);
        op8("t2a", 8'd5, 8'd9, 1'b0, 8'd252, 1'b1);
        step();
        op8("t2b", 8'd0, 8'd0, 1'b1, 8'd255, 1'b1);
        step();

        // start pulses while busy are ignored
        start8(8'd50, 8'd20, 1'b0);
        dones = 0;
        for (int c = 1; c <= 12; c++) begin
            bus8.start = (c == 3 || c == 5);
            bus8.a     = 8'd1;
            bus8.b     = 8'd2;
            if (bus8.done) dones++;
            if (c == 9) begin
                chk("t3_done9", 32'(bus8.done), 32'd1);
                chk("t3_diff", 32'(bus8.diff), 32'd30);
                chk("t3_bout", 32'(bus8.bout), 32'd0);
            end
            step();
        end
        bus8.start = 1'b0;
        chk("t3_ndone", 32'(dones), 32'd1);
        chk("t3_idle", 32'(bus8.busy), 32'd0);

        // Back-to-back: start held through the DONE cycle
        start8(8'd10, 8'd3, 1'b0);
        for (int c = 1; c <= 7; c++) step();
        bus8.start = 1'b1;
        bus8.a     = 8'd200;
        bus8.b     = 8'd55;
        bus8.bin   = 1'b0;
        step();
        chk("t4_done1", 32'(bus8.done), 32'd1);
        chk("t4_diff1", 32'(bus8.diff), 32'd7);
        step();
        bus8.start = 1'b0;
        chk("t4_rebusy", 32'(bus8.busy), 32'd1);
        chk("t4_hold", 32'(bus8.diff), 32'd7);
        for (int c = 10; c <= 17; c++) begin
            chk("t4_nodone", 32'(bus8.done), 32'd0);
            step();
        end
        chk("t4_done2", 32'(bus8.done), 32'd1);
        chk("t4_diff2", 32'(bus8.diff), 32'd145);
        chk("t4_bout2", 32'(bus8.bout), 32'd0);
        step();

        // Reset mid-run aborts the operation
        start8(8'd77, 8'd11, 1'b0);
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("t5_busy", 32'(bus8.busy), 32'd0);
        chk("t5_done", 32'(bus8.done), 32'd0);
        chk("t5_diff", 32'(bus8.diff), 32'd0);
        chk("t5_bout", 32'(bus8.bout), 32'd0);
        rst_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus8.done) dones++;
            step();
        end
        chk("t5_nodone", 32'(dones), 32'd0);
        op8("t5_fresh", 8'd9, 8'd4, 1'b1, 8'd4, 1'b0);
        step();

        // WIDTH 4 exhaustive sweep, issued back-to-back from each DONE cycle
        for (int i = 0; i < 512; i++) begin
            bus4.a     = 4'(i >> 5);
            bus4.b     = 4'(i >> 1);
            bus4.bin   = i[0];
            bus4.start = 1'b1;
            step();
            bus4.start = 1'b0;
            ref4 = {1'b0, bus4.a} - {1'b0, bus4.b} - {4'b0, bus4.bin};
            for (int k = 0; k < 4; k++) step();
            chk("t6_done", 32'(bus4.done), 32'd1);
            chk("t6_diff", 32'(bus4.diff), 32'(ref4[3:0]));
            chk("t6_bout", 32'(bus4.bout), 32'(ref4[4]));
        end
        step();
        chk("t6_idle", 32'(bus4.done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor. It computes diff = a - b - bin one bit per clock, LSB first, using a registered borrow. It is the inverse-operation counterpart of the team's gate-level full-adder cell. It serves area-constrained datapaths that trade latency for a single 1-bit full-subtractor cell, with a start/busy/done handshake to the controlling logic.

Parameters:
WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
start  input  1  request pulse; sampled only when busy = 0.
a  input  WIDTH  minuend; captured when start is accepted.
b  input  WIDTH  subtrahend; captured when start is accepted.
bin  input  1  borrow-in; captured when start is accepted.
busy  output  1  high while an operation is in progress.
done  output  1  single-cycle pulse; diff and bout are valid.
diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH.
bout  output  1  borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low (rst_n).
- Reset: while rst_n = 0 at a rising edge, the block enters IDLE and clears all outputs: busy = 0, done = 0, diff = 0, bout = 0. The internal shift registers, borrow flop and bit counter also clear to 0.
- FSM has three states:
  - IDLE: busy = 0, done = 0.
  - RUN: busy = 1.
  - DONE: busy = 0, done = 1, lasting one cycle.
- Transitions:
  - IDLE -> RUN when start = 1. The block captures a and b into shift registers, bin into the borrow flop, and sets count = 0.
  - RUN: each cycle processes bit i = count:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - d_i shifts into the MSB of the result register. The operand registers shift right. count increments.
  - RUN -> DONE after WIDTH bit-cycles (count = WIDTH-1 processed). diff is loaded from the result register and bout from the final borrow.
  - DONE -> RUN if start = 1 in the DONE cycle, giving back-to-back operation with new operands captured. Otherwise DONE -> IDLE.
- Latency: start is sampled in cycle 0. busy = 1 in cycles 1..WIDTH. done = 1 and the result is valid in cycle WIDTH+1.
- start while busy = 1 is ignored. The operand inputs are don't-care while busy.
- diff and bout hold their last value until the next DONE or a reset. They do not change during a subsequent RUN.
- Reset asserted mid-RUN aborts the operation immediately at that edge. No done pulse is produced, and all outputs read as reset values.
- Counter width is $clog2(WIDTH). Counting is unsigned. All arithmetic is modulo 2^WIDTH, with no overflow flag beyond bout.

Decomposition:
- Shared package serial_arith_pkg holds:
  - the FSM state typedef (IDLE, RUN, DONE; 2-bit encoding);
  - a localparam helper for the counter width.
- One sub-module, full_subtractor_gate: 1-bit combinational cell with inputs A, B, Bin and outputs Diff, Bout, built from gate primitives. It mirrors the adder cell's style.
- The top level instantiates this cell once and owns the FSM, shift registers, borrow flop and counter.

Test Plan:
1. WIDTH = 8; a = 100, b = 37, bin = 0, start pulsed in cycle 0 -> busy high in cycles 1-8; done = 1 in cycle 9 with diff = 63, bout = 0.
2. a = 5, b = 9, bin = 0 -> diff = 252 (0xFC), bout = 1. Then a = 0, b = 0, bin = 1 -> diff = 255, bout = 1.
3. start re-pulsed with different operands in cycles 3 and 5 of an active operation -> ignored; result matches the first operands; exactly one done pulse.
4. start held high through the DONE cycle with a = 200, b = 55 -> busy re-asserts in the next cycle; second done 9 cycles after the first with diff = 145, bout = 0.
5. rst_n driven low in cycle 4 of a RUN -> at that edge busy = 0, diff = 0, bout = 0; no done pulse follows. A fresh start afterwards computes correctly.
6. WIDTH = 4: all 512 combinations of a, b and bin -> diff == (a - b - bin) mod 16 and bout == (a < b + bin), each checked on its done pulse.
